// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Sequences the resets of a MIPS-core SoC from a single PLL clock. Lock must
//   be stable for LOCK_STABLE_CYCLES cycles before the core is released. The
//   UART and peripherals follow STAGE_GAP cycles later. A filtered loss of lock
//   while running, or any loss of lock during release, restarts qualification
//   and bumps a saturating lock-loss counter. A soft-reset request pulses both
//   resets for STAGE_GAP cycles and then replays the staged release.
//
// Ports:
//   clk           in   100 MHz PLL output clock; the only clock
//   rst           in   asynchronous active-high reset
//   pll_locked    in   PLL lock, asynchronous to clk (synchronized inside)
//   sw_reset_req  in   single-cycle soft-reset request, synchronous to clk
//   rst_core      out  active-high reset for the MIPS core
//   rst_uart      out  active-high reset for the UART and peripherals
//   sys_ready     out  high only while running
//   lock_loss_cnt out  count of lock-loss events, saturates at 255
//   state_o       out  current FSM state code, for debug
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int LOSS_FILTER        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       rst_core,
    output logic       rst_uart,
    output logic       sys_ready,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_WAIT     = 3'd0,
        S_STABLE   = 3'd1,
        S_REL_CORE = 3'd2,
        S_RUN      = 3'd3,
        S_SOFT     = 3'd4
    } state_t;

    // Each counter only ever reaches (limit - 1), so $clog2(limit) bits suffice.
    localparam int STB_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP > 1)          ? $clog2(STAGE_GAP)          : 1;
    localparam int LOSS_W = (LOSS_FILTER > 1)        ? $clog2(LOSS_FILTER)        : 1;

    localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);

    state_t            r_state;
    logic [1:0]        r_sync;
    logic [STB_W-1:0]  r_stable_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [LOSS_W-1:0] r_loss_cnt;
    logic [7:0]        r_lock_loss_cnt;
    logic              r_rst_core;
    logic              r_rst_uart;
    logic              r_sys_ready;

    state_t            w_next_state;
    logic [STB_W-1:0]  w_stable_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic [LOSS_W-1:0] w_loss_nxt;
    logic              w_loss_event;
    logic              w_lock_s;

    assign w_lock_s = r_sync[1];

    // Next-state and counter logic. Within each state, lock loss is tested
    // first, then the soft-reset request, then counter expiry.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_stable_nxt = r_stable_cnt;
        w_gap_nxt    = r_gap_cnt;
        w_loss_nxt   = r_loss_cnt;
        w_loss_event = 1'b0;

        case (r_state)
            S_WAIT: begin
                if (w_lock_s) begin
                    w_next_state = S_STABLE;
                    w_stable_nxt = '0;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_next_state = S_WAIT;
                end else if (r_stable_cnt == STB_LAST) begin
                    w_next_state = S_REL_CORE;
                    w_gap_nxt    = '0;
                end else begin
                    w_stable_nxt = r_stable_cnt + STB_W'(1);
                end
            end
            S_REL_CORE: begin
                // No filtering here: the core has just come out of reset on a
                // clock that may be unstable, so any low lock sample aborts.
                if (!w_lock_s) begin
                    w_next_state = S_WAIT;
                    w_loss_event = 1'b1;
                end else if (sw_reset_req) begin
                    w_next_state = S_SOFT;
                    w_gap_nxt    = '0;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = S_RUN;
                    w_loss_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            S_RUN: begin
                if (!w_lock_s && (r_loss_cnt == LOSS_LAST)) begin
                    w_next_state = S_WAIT;
                    w_loss_event = 1'b1;
                end else if (sw_reset_req) begin
                    w_next_state = S_SOFT;
                    w_gap_nxt    = '0;
                end else if (!w_lock_s) begin
                    w_loss_nxt = r_loss_cnt + LOSS_W'(1);
                end else begin
                    w_loss_nxt = '0;
                end
            end
            S_SOFT: begin
                if (!w_lock_s) begin
                    w_next_state = S_WAIT;
                    w_loss_event = 1'b1;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = S_REL_CORE;
                    w_gap_nxt    = '0;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: w_next_state = S_WAIT;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the transition. rst_uart is high in every state where rst_core is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_WAIT;
            r_sync          <= '0;
            r_stable_cnt    <= '0;
            r_gap_cnt       <= '0;
            r_loss_cnt      <= '0;
            r_lock_loss_cnt <= '0;
            r_rst_core      <= 1'b1;
            r_rst_uart      <= 1'b1;
            r_sys_ready     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_sync       <= {r_sync[0], pll_locked};
            r_state      <= w_next_state;
            r_stable_cnt <= w_stable_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_loss_cnt   <= w_loss_nxt;
            if (w_loss_event && (r_lock_loss_cnt != 8'hFF)) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
            end
            r_rst_core  <= !((w_next_state == S_REL_CORE) || (w_next_state == S_RUN));
            r_rst_uart  <= (w_next_state != S_RUN);
            r_sys_ready <= (w_next_state == S_RUN);
        end
    end

    assign rst_core      = r_rst_core;
    assign rst_uart      = r_rst_uart;
    assign sys_ready     = r_sys_ready;
    assign lock_loss_cnt = r_lock_loss_cnt;
    assign state_o       = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Purpose:
//   Self-checking bench for pll_reset_sequencer with LOCK_STABLE_CYCLES=8,
//   STAGE_GAP=4, LOSS_FILTER=3. A table of {inputs, cycle count, expected
//   outputs} rows is driven one cycle at a time on the falling edge; each
//   cycle's expectation goes into a scoreboard queue and is popped and compared
//   1 ns after the following rising edge. Hand-written sequences cover the
//   asynchronous reset and lock-loss counter saturation.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam logic [2:0] W  = 3'd0;
    localparam logic [2:0] S  = 3'd1;
    localparam logic [2:0] RC = 3'd2;
    localparam logic [2:0] R  = 3'd3;
    localparam logic [2:0] SF = 3'd4;

    typedef struct {
        int         row;
        logic [2:0] st;
        logic       rc;
        logic       ru;
        logic       rdy;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic       lk;
        logic       sw;
        int         n;
        logic [2:0] st;
        logic       rc;
        logic       ru;
        logic       rdy;
        logic [7:0] cnt;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       rst_core;
    logic       rst_uart;
    logic       sys_ready;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    vec_t vq[$];

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .STAGE_GAP         (4),
        .LOSS_FILTER       (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .rst_core     (rst_core),
        .rst_uart     (rst_uart),
        .sys_ready    (sys_ready),
        .lock_loss_cnt(lock_loss_cnt),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic lk, input logic sw, input int n, input logic [2:0] st,
                       input logic rc, input logic ru, input logic rdy, input logic [7:0] cnt);
        vec_t v;
        v = '{lk: lk, sw: sw, n: n, st: st, rc: rc, ru: ru, rdy: rdy, cnt: cnt};
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs and optionally queue what the outputs must be
    // after the next rising edge.
    task automatic drive(input logic lk, input logic sw, input bit chk, input exp_t e);
        @(negedge clk);
        pll_locked   = lk;
        sw_reset_req = sw;
        if (chk) exp_q.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] st, input logic rc,
                                 input logic ru, input logic rdy, input logic [7:0] cnt);
        check({tag, ".state"},    {29'd0, state_o},       {29'd0, st});
        check({tag, ".rst_core"}, {31'd0, rst_core},      {31'd0, rc});
        check({tag, ".rst_uart"}, {31'd0, rst_uart},      {31'd0, ru});
        check({tag, ".ready"},    {31'd0, sys_ready},     {31'd0, rdy});
        check({tag, ".loss_cnt"}, {24'd0, lock_loss_cnt}, {24'd0, cnt});
    endtask

    // Scoreboard side: compare after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) check("uart_not_before_core", {31'd0, rst_core & ~rst_uart}, 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_outputs($sformatf("row%0d", e.row), e.st, e.rc, e.ru, e.rdy, e.cnt);
            end
        end
    end

    initial begin
        exp_t e;
        int   model_cnt;

        // ---------------- stimulus table ----------------
        // Startup from lock at cycle 0: core released on the 11th edge, UART on
        // the 15th. Requests in WAIT and STABLE are ignored.
        row(1, 1, 1, W,  1, 1, 0, 0);
        row(1, 0, 1, W,  1, 1, 0, 0);
        row(1, 1, 1, S,  1, 1, 0, 0);
        row(1, 0, 7, S,  1, 1, 0, 0);
        row(1, 0, 4, RC, 0, 1, 0, 0);
        row(1, 0, 3, R,  0, 0, 1, 0);
        // Two-cycle lock glitch in RUN: filtered out.
        row(0, 0, 2, R,  0, 0, 1, 0);
        row(1, 0, 6, R,  0, 0, 1, 0);
        // Soft reset from RUN; a second request inside SOFT is ignored.
        row(1, 1, 1, SF, 1, 1, 0, 0);
        row(1, 0, 1, SF, 1, 1, 0, 0);
        row(1, 1, 1, SF, 1, 1, 0, 0);
        row(1, 0, 1, SF, 1, 1, 0, 0);
        row(1, 0, 4, RC, 0, 1, 0, 0);
        row(1, 0, 2, R,  0, 0, 1, 0);
        // Filtered lock loss coinciding with a soft-reset request: loss wins.
        row(0, 0, 4, R,  0, 0, 1, 0);
        row(0, 1, 1, W,  1, 1, 0, 1);
        row(0, 0, 3, W,  1, 1, 0, 1);
        // Lock high for only 5 cycles: back to WAIT, nothing released.
        row(1, 0, 2, W,  1, 1, 0, 1);
        row(1, 0, 3, S,  1, 1, 0, 1);
        row(0, 0, 2, S,  1, 1, 0, 1);
        row(0, 0, 3, W,  1, 1, 0, 1);
        // Full 8-cycle qualification again, then unfiltered loss in REL_CORE
        // together with a soft-reset request.
        row(1, 0, 2, W,  1, 1, 0, 1);
        row(1, 0, 8, S,  1, 1, 0, 1);
        row(1, 0, 1, RC, 0, 1, 0, 1);
        row(0, 0, 2, RC, 0, 1, 0, 1);
        row(0, 1, 1, W,  1, 1, 0, 2);
        row(0, 0, 2, W,  1, 1, 0, 2);
        // Soft reset from REL_CORE, staged release, then lock loss in SOFT.
        row(1, 0, 2, W,  1, 1, 0, 2);
        row(1, 0, 8, S,  1, 1, 0, 2);
        row(1, 0, 2, RC, 0, 1, 0, 2);
        row(1, 1, 1, SF, 1, 1, 0, 2);
        row(1, 0, 3, SF, 1, 1, 0, 2);
        row(1, 0, 4, RC, 0, 1, 0, 2);
        row(1, 0, 1, R,  0, 0, 1, 2);
        row(1, 1, 1, SF, 1, 1, 0, 2);
        row(0, 0, 2, SF, 1, 1, 0, 2);
        row(0, 0, 1, W,  1, 1, 0, 3);
        row(0, 0, 2, W,  1, 1, 0, 3);

        // ---------------- reset state ----------------
        rst          = 1'b1;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", W, 1, 1, 0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table replay ----------------
        foreach (vq[i]) begin
            for (int k = 0; k < vq[i].n; k++) begin
                e = '{row: i, st: vq[i].st, rc: vq[i].rc, ru: vq[i].ru,
                      rdy: vq[i].rdy, cnt: vq[i].cnt};
                drive(vq[i].lk, vq[i].sw, 1'b1, e);
            end
        end

        // ---------------- asynchronous reset in REL_CORE ----------------
        for (int k = 0; k < 11; k++) begin
            e = '{row: 100, st: RC, rc: 1'b0, ru: 1'b1, rdy: 1'b0, cnt: 8'd3};
            drive(1'b1, 1'b0, (k == 10), e);
        end
        @(posedge clk);
        #1;
        check("async_pre.state", {29'd0, state_o}, {29'd0, RC});
        #2;
        rst        = 1'b1;
        pll_locked = 1'b0;
        #1;
        check_outputs("async_rst", W, 1, 1, 0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("async_hold", W, 1, 1, 0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- lock-loss counter saturation ----------------
        // Each pass qualifies lock from scratch and drops it in REL_CORE.
        model_cnt = 0;
        for (int it = 0; it < 300; it++) begin
            if (model_cnt < 255) model_cnt++;
            for (int k = 0; k < 11; k++) drive(1'b1, 1'b0, 1'b0, e);
            drive(1'b0, 1'b0, 1'b0, e);
            drive(1'b0, 1'b0, 1'b0, e);
            e = '{row: 200 + it, st: W, rc: 1'b1, ru: 1'b1, rdy: 1'b0, cnt: 8'(model_cnt)};
            drive(1'b0, 1'b0, 1'b1, e);
        end

        repeat (2) @(posedge clk);
        #2;
        check("saturated_cnt", {24'd0, lock_loss_cnt}, 32'd255);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
